scan_sequencer: RTL and testbench



---
 rtl/scan_sequencer.sv | 149 ++++++++++++++
 tb/tb_scan_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scan_sequencer.sv
// scan_sequencer
//
// Drives the D2/D1/D0 select inputs of a 3-to-8 decoder for an 8-channel
// strobe scan. It walks the unmasked channels in ascending order and holds
// each one for DWELL cycles. One START runs either a single sweep or
// continuous sweeps. DONE pulses once at each sweep completion.
//
// Parameters:
//   DWELL   cycles each channel is held (1..256)
//
// Ports:
//   CLK     clock, rising edge
//   RST     synchronous active-high reset
//   START   begin a scan (only looked at while idle)
//   STOP    abort; beats START in idle, beats dwell end / sweep end in scan
//   CONT    continuous mode, captured when START is accepted
//   MASK    bit i = 1 skips channel i, captured when START is accepted
//   D2..D0  registered channel code
//   ACTIVE  registered, high while the channel code is valid
//   DONE    registered one-cycle pulse at each sweep completion
module scan_sequencer #(
  parameter int unsigned DWELL = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       STOP,
  input  logic       CONT,
  input  logic [7:0] MASK,
  output logic       D2,
  output logic       D1,
  output logic       D0,
  output logic       ACTIVE,
  output logic       DONE
);

  // The dwell counter runs 0..DWELL-1, so DWELL=256 still fits in 8 bits.
  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic {IDLE, SCAN} state_t;

  state_t     state_reg;
  logic [2:0] chan_reg;
  logic [7:0] cnt_reg;
  logic       active_reg;
  logic       done_reg;
  logic [7:0] mask_reg;
  logic       cont_reg;

  // Lowest channel index whose mask bit is clear (0 when all are set;
  // callers check for that case separately).
  function automatic logic [2:0] lowest_clear(input logic [7:0] m);
    logic [2:0] r;
    r = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (!m[i]) r = 3'(i);
    end
    return r;
  endfunction

  // Channels at or below the current one count as "blocked" when looking
  // for the next channel, so the search only ever moves upward.
  logic [7:0] passed_mask;
  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_passed
      assign passed_mask[gi] = (3'(gi) <= chan_reg);
    end
  endgenerate

  logic [7:0] ahead_blocked;
  logic       next_valid;
  logic [2:0] next_chan;
  logic [2:0] first_chan;
  logic [2:0] start_chan;

  assign ahead_blocked = mask_reg | passed_mask;
  assign next_valid    = ~&ahead_blocked;
  assign next_chan     = lowest_clear(ahead_blocked);
  assign first_chan    = lowest_clear(mask_reg);
  assign start_chan    = lowest_clear(MASK);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_reg  <= IDLE;
      chan_reg   <= 3'd0;
      cnt_reg    <= 8'd0;
      active_reg <= 1'b0;
      done_reg   <= 1'b0;
      mask_reg   <= 8'd0;
      cont_reg   <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          chan_reg   <= 3'd0;
          cnt_reg    <= 8'd0;
          active_reg <= 1'b0;
          if (START && !STOP) begin
            mask_reg <= MASK;
            cont_reg <= CONT;
            if (&MASK) begin
              // Nothing to scan: report an empty sweep immediately.
              done_reg <= 1'b1;
            end else begin
              state_reg  <= SCAN;
              chan_reg   <= start_chan;
              active_reg <= 1'b1;
            end
          end
        end

        SCAN: begin
          if (STOP) begin
            state_reg  <= IDLE;
            chan_reg   <= 3'd0;
            cnt_reg    <= 8'd0;
            active_reg <= 1'b0;
          end else if (cnt_reg == DWELL_LAST) begin
            cnt_reg <= 8'd0;
            if (next_valid) begin
              chan_reg <= next_chan;
            end else begin
              done_reg <= 1'b1;
              if (cont_reg) begin
                chan_reg <= first_chan;
              end else begin
                state_reg  <= IDLE;
                chan_reg   <= 3'd0;
                active_reg <= 1'b0;
              end
            end
          end else begin
            cnt_reg <= cnt_reg + 8'd1;
          end
        end

        default: state_reg <= IDLE;
      endcase
    end
  end

  assign D2     = chan_reg[2];
  assign D1     = chan_reg[1];
  assign D0     = chan_reg[0];
  assign ACTIVE = active_reg;
  assign DONE   = done_reg;

endmodule

// File: tb/tb_scan_sequencer.sv
// Testbench for scan_sequencer. Four instances with DWELL = 4, 2, 3, 1
// share the same stimulus. A reference model describes each scan as
// "list of unmasked channels, each repeated DWELL times" indexed by the
// number of cycles since START was accepted.
module tb_scan_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       START;
  logic       STOP;
  logic       CONT;
  logic [7:0] MASK;

  logic [3:0] d2, d1, d0, act, dn;
  logic [19:0] obs;
  logic [19:0] exp_v;

  int n_cmp  = 0;
  int n_fail = 0;

  int dwv [4] = '{4, 2, 3, 1};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_dut
      localparam int unsigned DW = (gi == 0) ? 4 : (gi == 1) ? 2 : (gi == 2) ? 3 : 1;
      scan_sequencer #(.DWELL(DW)) u_dut (
        .CLK    (CLK),
        .RST    (RST),
        .START  (START),
        .STOP   (STOP),
        .CONT   (CONT),
        .MASK   (MASK),
        .D2     (d2[gi]),
        .D1     (d1[gi]),
        .D0     (d0[gi]),
        .ACTIVE (act[gi]),
        .DONE   (dn[gi])
      );
      assign obs[5*gi +: 5] = {d2[gi], d1[gi], d0[gi], act[gi], dn[gi]};
    end
  endgenerate

  always #5 CLK = ~CLK;

  // ---------------- reference model ----------------
  bit         busy [4];
  int         t    [4];
  int         lst  [4][8];
  int         mm   [4];
  bit         cc   [4];
  logic [2:0] e_ch [4];
  bit         e_act[4];
  bit         e_dn [4];

  task automatic model_edge();
    int len, tt;
    for (int k = 0; k < 4; k++) begin
      if (RST) begin
        busy[k] = 0; e_ch[k] = 3'd0; e_act[k] = 0; e_dn[k] = 0;
      end else if (!busy[k]) begin
        e_ch[k] = 3'd0; e_act[k] = 0; e_dn[k] = 0;
        if (START && !STOP) begin
          mm[k] = 0;
          for (int c = 0; c < 8; c++)
            if (!MASK[c]) begin lst[k][mm[k]] = c; mm[k]++; end
          cc[k] = CONT;
          if (mm[k] == 0) e_dn[k] = 1;
          else begin
            busy[k] = 1; t[k] = 0; e_ch[k] = 3'(lst[k][0]); e_act[k] = 1;
          end
        end
      end else if (STOP) begin
        busy[k] = 0; e_ch[k] = 3'd0; e_act[k] = 0; e_dn[k] = 0;
      end else begin
        t[k]++;
        len = mm[k] * dwv[k];
        if (!cc[k] && t[k] == len) begin
          busy[k] = 0; e_ch[k] = 3'd0; e_act[k] = 0; e_dn[k] = 1;
        end else begin
          tt = t[k] % len;
          e_ch[k]  = 3'(lst[k][tt / dwv[k]]);
          e_act[k] = 1;
          e_dn[k]  = (tt == 0);
        end
      end
      exp_v[5*k +: 5] = {e_ch[k], e_act[k], e_dn[k]};
    end
  endtask

  // Advance one clock, update the model, sample 1 time unit after the edge.
  task automatic step();
    @(posedge CLK);
    model_edge();
    #1;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    RST = 1; START = 0; STOP = 0; CONT = 0; MASK = 8'h00;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== 20'h0 || obs !== exp_v) begin
        n_fail++; $display("FAIL reset: got %h want %h", obs, exp_v);
      end
    end
    RST = 0;
  endtask

  task automatic test_single_sweep();
    int act_cyc = 0, done_cnt = 0;
    MASK = 8'h00; CONT = 0; START = 1;
    for (int i = 0; i < 37; i++) begin
      step();
      START = 0;
      act_cyc += act[0]; done_cnt += dn[0];
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL single_sweep cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (act_cyc !== 32 || done_cnt !== 1) begin
      n_fail++; $display("FAIL single_sweep_len: active=%0d done=%0d want 32/1", act_cyc, done_cnt);
    end
  endtask

  task automatic test_masked();
    logic [7:0] m = 8'b1010_0101;
    int act_cyc = 0;
    MASK = m; CONT = 0; START = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      START = 0;
      act_cyc += act[1];
      n_cmp++;
      if (obs !== exp_v || (act[1] && m[{d2[1], d1[1], d0[1]}])) begin
        n_fail++; $display("FAIL masked cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (act_cyc !== 8) begin
      n_fail++; $display("FAIL masked_len: active=%0d want 8", act_cyc);
    end
  endtask

  task automatic test_continuous();
    int done_cnt = 0;
    MASK = 8'hFE; CONT = 1; START = 1;
    for (int i = 0; i < 31; i++) begin
      step();
      START = 0;
      if (i > 0) done_cnt += dn[2];
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL continuous cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    n_cmp++;
    if (done_cnt !== 10) begin
      n_fail++; $display("FAIL continuous_done: got %0d want 10", done_cnt);
    end
    STOP = 1;
    step();
    STOP = 0;
    n_cmp++;
    if (obs !== 20'h0 || obs !== exp_v) begin
      n_fail++; $display("FAIL continuous_stop: got %h want %h", obs, exp_v);
    end
    for (int i = 0; i < 4; i++) begin
      step();
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL continuous_after_stop: got %h want %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_all_masked();
    MASK = 8'hFF; CONT = 0; START = 1;
    step();
    START = 0;
    n_cmp++;
    if (dn !== 4'hF || act !== 4'h0 || obs !== exp_v) begin
      n_fail++; $display("FAIL all_masked_done: got %h want %h", obs, exp_v);
    end
    step();
    n_cmp++;
    if (obs !== 20'h0 || obs !== exp_v) begin
      n_fail++; $display("FAIL all_masked_after: got %h want %h", obs, exp_v);
    end
    MASK = 8'h00; START = 1; STOP = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_cmp++;
      if (obs !== 20'h0 || obs !== exp_v) begin
        n_fail++; $display("FAIL start_and_stop: got %h want %h", obs, exp_v);
      end
    end
    START = 0; STOP = 0;
  endtask

  task automatic test_mid_scan_changes();
    MASK = 8'($urandom);
    MASK[$urandom_range(7, 0)] = 1'b0;
    CONT = 0; START = 1;
    for (int i = 0; i < 40; i++) begin
      step();
      START = 1'($urandom); MASK = 8'($urandom); CONT = 1'($urandom);
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL mid_scan cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    START = 0; STOP = 1;
    step();
    STOP = 0;
    // Stop landing on the sweep-completion edge of the DWELL=4 instance.
    MASK = 8'h00; CONT = 0; START = 1;
    step();
    START = 0;
    for (int i = 0; i < 31; i++) step();
    STOP = 1;
    step();
    STOP = 0;
    n_cmp++;
    if (act[0] !== 1'b0 || dn[0] !== 1'b0 || obs !== exp_v) begin
      n_fail++; $display("FAIL stop_at_completion: got %h want %h", obs, exp_v);
    end
  endtask

  task automatic test_reset_mid_scan();
    MASK = 8'h00; CONT = 0; START = 1;
    step();
    START = 0;
    for (int i = 0; i < 20; i++) step();
    n_cmp++;
    if ({d2[0], d1[0], d0[0]} !== 3'd5 || obs !== exp_v) begin
      n_fail++; $display("FAIL pre_reset_chan5: got %h want %h", obs, exp_v);
    end
    RST = 1;
    for (int i = 0; i < 2; i++) begin
      step();
      n_cmp++;
      if (obs !== 20'h0 || obs !== exp_v) begin
        n_fail++; $display("FAIL reset_mid_scan: got %h want %h", obs, exp_v);
      end
    end
    RST = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      n_cmp++;
      if (obs !== 20'h0 || obs !== exp_v) begin
        n_fail++; $display("FAIL idle_after_reset: got %h want %h", obs, exp_v);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      RST   = ($urandom_range(99, 0) == 0);
      START = ($urandom_range(3, 0) == 0);
      STOP  = ($urandom_range(15, 0) == 0);
      CONT  = 1'($urandom);
      MASK  = ($urandom_range(9, 0) == 0) ? 8'hFF : 8'($urandom);
      step();
      n_cmp++;
      if (obs !== exp_v) begin
        n_fail++; $display("FAIL random cyc%0d: got %h want %h", i, obs, exp_v);
      end
    end
    RST = 0; START = 0; STOP = 0;
  endtask

  initial begin
    RST = 1; START = 0; STOP = 0; CONT = 0; MASK = 8'h00;
    test_reset();
    test_single_sweep();
    test_masked();
    test_continuous();
    test_all_masked();
    test_mid_scan_changes();
    test_reset_mid_scan();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
